// File: rtl/mc_mips_core_if.sv
// Unified memory port of the multi-cycle core: one request at a time,
// completing on the cycle where mem_req && mem_ready.
interface mc_mips_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mc_mips_core.sv
// Multi-cycle MIPS-subset core with a shared datapath and a unified memory port.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module mc_mips_core #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_mips_core_if.master       mem_bus,
  output logic [31:0]          pc_out,
  output logic                 retire,
  output logic                 halted,
  output logic [31:0]          cycle_count,
  output logic [31:0]          instr_count
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [31:0]        pc_q, pc_d, ir_q, mdr_q;
  logic signed [31:0] a_q, b_q, alu_q;
  logic [31:0]        rf_q [32];

  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        retire_q, retire_d, halted_q, halted_d;

  logic [5:0]         op, funct;
  logic [4:0]         rs, rt, rd, wb_dst;
  logic signed [31:0] imm_s;
  logic is_nop, is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, illegal;
  logic               mem_done, misaligned;
  logic signed [31:0] opa_s, opb_s, alu_res;
  logic [31:0]        pc_plus4, br_target, j_target, wb_data;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm_s  = {{16{ir_q[15]}}, ir_q[15:0]};

  assign is_nop   = (ir_q == 32'h0);
  assign is_rtype = (op == 6'h00) && ((funct == 6'h20) || (funct == 6'h22) ||
                    (funct == 6'h24) || (funct == 6'h25) || (funct == 6'h2A));
  assign is_addi  = (op == 6'h08);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_beq   = (op == 6'h04);
  assign is_j     = (op == 6'h02);
  assign illegal  = !(is_nop || is_rtype || is_addi || is_lw || is_sw || is_beq || is_j);

  assign mem_done  = mem_req_q && mem_bus.mem_ready;
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_s[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign wb_dst    = is_rtype ? rd : rt;
  assign wb_data   = is_lw ? mdr_q : alu_q;

  always_comb begin
    opa_s   = a_q;
    opb_s   = is_rtype ? b_q : imm_s;
    alu_res = opa_s + opb_s;
    if (is_rtype) begin
      case (funct)
        6'h22:   alu_res = opa_s - opb_s;
        6'h24:   alu_res = opa_s & opb_s;
        6'h25:   alu_res = opa_s | opb_s;
        6'h2A:   alu_res = {31'b0, (opa_s < opb_s)};
        default: alu_res = opa_s + opb_s;
      endcase
    end
  end

  assign misaligned = ALIGN_CHECK && (alu_res[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        if (illegal)              state_d = S_HALT;
        else if (is_j || is_nop)  state_d = S_FETCH;
        else                      state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_beq)               state_d = S_FETCH;
        else if (is_lw || is_sw)  state_d = misaligned ? S_HALT : S_MEM;
        else                      state_d = S_WB;
      end
      S_MEM:    if (mem_done) state_d = is_sw ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RST;
    endcase
  end

  // Output logic: next values of the registered outputs; PC moves only at retire
  always_comb begin
    pc_d     = pc_q;
    retire_d = 1'b0;
    case (state_q)
      S_DECODE: begin
        if (is_j)        begin pc_d = j_target; retire_d = 1'b1; end
        else if (is_nop) begin pc_d = pc_plus4; retire_d = 1'b1; end
      end
      S_EXEC: if (is_beq) begin
        pc_d     = (a_q == b_q) ? br_target : pc_plus4;
        retire_d = 1'b1;
      end
      S_MEM:  if (mem_done && is_sw) begin pc_d = pc_plus4; retire_d = 1'b1; end
      S_WB:   begin pc_d = pc_plus4; retire_d = 1'b1; end
      default: ;
    endcase

    mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_we_d    = (state_d == S_MEM) && is_sw;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == S_FETCH) begin
      mem_addr_d = pc_d;
    end else if ((state_d == S_MEM) && (state_q == S_EXEC)) begin
      mem_addr_d  = {alu_res[31:2], 2'b00};
      mem_wdata_d = b_q;
    end
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= RESET_PC;
      mem_wdata_q <= 32'h0;
      retire_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      retire_q    <= retire_d;
      halted_q    <= halted_d;
    end
  end

  // Shared datapath registers and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q  <= 32'h0;
      mdr_q <= 32'h0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_done) ir_q <= mem_bus.mem_rdata;
        S_DECODE: begin
          a_q <= rf_q[rs];
          b_q <= rf_q[rt];
        end
        S_EXEC:   alu_q <= alu_res;
        S_MEM:    if (mem_done && is_lw) mdr_q <= mem_bus.mem_rdata;
        S_WB:     if (wb_dst != 5'd0) rf_q[wb_dst] <= wb_data;
        default: ;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_q, icnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q  <= 32'h0;
      icnt_q <= 32'h0;
    end else begin
      if ((state_q != S_RST) && (state_q != S_HALT)) cyc_q <= cyc_q + 32'd1;
      if (retire_d) icnt_q <= icnt_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
  assign instr_count = icnt_q;
`else
  assign cycle_count = 32'h0;
  assign instr_count = 32'h0;
`endif

  assign mem_bus.mem_req   = mem_req_q;
  assign mem_bus.mem_we    = mem_we_q;
  assign mem_bus.mem_addr  = mem_addr_q;
  assign mem_bus.mem_wdata = mem_wdata_q;
  assign pc_out            = pc_q;
  assign retire            = retire_q;
  assign halted            = halted_q;

endmodule
